// File: rtl/text_msg_ctrl.sv
// Text overlay controller: loads a ROM message into a double buffer and swaps it in at vblank start.
// Lookup latency 1 cycle; fill takes WIDTH+1 cycles; requests are only accepted in IDLE (msg_ready), never queued.
module text_msg_ctrl #(
   parameter int         WIDTH        = 32,
   parameter int         MSG_ID_W     = 3,
   parameter int         BLINK_FRAMES = 30,
   parameter logic [6:0] BLANK_CODE   = 7'h20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  msg_req,
   input  logic [MSG_ID_W-1:0]   msg_id,
   output logic                  msg_ready,
   output logic                  busy,
   output logic                  done,
   output logic [MSG_ID_W+4:0]   rom_addr,
   input  logic [6:0]            rom_data,
   input  logic                  vblnk,
   input  logic                  show,
   input  logic                  blink_en,
   input  logic [7:0]            char_xy,
   output logic [6:0]            char_code,
   output logic                  enable
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

   typedef enum logic [1:0] {IDLE, FILL, WAIT_VBL, DONE} state_t;

   state_t              state, state_nxt;
   logic [MSG_ID_W-1:0] id_q;
   logic [5:0]          idx;
   logic                vbl_d;
   logic                vbl_start;
   logic                accept;
   logic                swap;
   logic                front_sel;
   logic                front_valid;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                phase, phase_nxt;
   logic [6:0]          mem [2][WIDTH];

   assign vbl_start = vblnk & ~vbl_d;
   assign accept    = msg_req & msg_ready;
   assign swap      = (state == WAIT_VBL) & vbl_start;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = FILL;
         FILL:     if (idx == 6'(WIDTH)) state_nxt = WAIT_VBL;
         WAIT_VBL: if (vbl_start) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // DONE is the first cycle showing the new front buffer; msg_ready waits one more cycle.
   always_comb begin
      msg_ready = (state == IDLE) & ~rst;
      busy      = (state == FILL) | (state == WAIT_VBL);
      done      = (state == DONE);
      rom_addr  = '0;
      if (state == FILL) rom_addr = {id_q, idx[4:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_q  <= '0;
         idx   <= '0;
         vbl_d <= 1'b0;
      end else begin
         vbl_d <= vblnk;
         if (accept) begin
            id_q <= msg_id;
            idx  <= '0;
         end else if (state == FILL) begin
            idx <= idx + 6'd1;
         end
      end
   end

   // ROM data lags the address by one cycle, so write slot idx-1 into the back buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < WIDTH; i++)
               mem[b][i] <= BLANK_CODE;
      end else if ((state == FILL) && (idx != 6'd0)) begin
         mem[~front_sel][IDX_W'(idx - 6'd1)] <= rom_data;
      end
   end

   always_comb begin
      cnt_nxt   = cnt;
      phase_nxt = phase;
      if (!blink_en) begin
         cnt_nxt   = '0;
         phase_nxt = 1'b1;
      end else if (vbl_start) begin
         if (cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt_nxt   = '0;
            phase_nxt = ~phase;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         front_sel   <= 1'b0;
         front_valid <= 1'b0;
         cnt         <= '0;
         phase       <= 1'b1;
         enable      <= 1'b0;
         char_code   <= BLANK_CODE;
      end else begin
         cnt   <= cnt_nxt;
         phase <= phase_nxt;
         if (swap) begin
            front_sel   <= ~front_sel;
            front_valid <= 1'b1;
         end
         if (vbl_start) enable <= show & (front_valid | swap) & phase_nxt;
         char_code <= (char_xy < 8'(WIDTH)) ? mem[front_sel][char_xy[IDX_W-1:0]] : BLANK_CODE;
      end
   end

endmodule

// File: tb/tb_text_msg_ctrl.sv
// Directed bench for text_msg_ctrl: ROM returns addr[6:0] one cycle late, BLINK_FRAMES=2.
// Outputs are sampled 1 ns after each rising edge, inputs change at the same point.
module tb_text_msg_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       msg_req = 1'b0;
   logic [2:0] msg_id = '0;
   logic       msg_ready, busy, done, enable;
   logic [7:0] rom_addr;
   logic [6:0] rom_data = '0;
   logic       vblnk = 1'b0;
   logic       show = 1'b0;
   logic       blink_en = 1'b0;
   logic [7:0] char_xy = '0;
   logic [6:0] char_code;

   int vectors = 0;
   int miscompares = 0;
   logic blink_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   text_msg_ctrl #(.WIDTH(32), .MSG_ID_W(3), .BLINK_FRAMES(2), .BLANK_CODE(7'h20)) dut (
      .clk(clk), .rst(rst), .msg_req(msg_req), .msg_id(msg_id), .msg_ready(msg_ready),
      .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data), .vblnk(vblnk),
      .show(show), .blink_en(blink_en), .char_xy(char_xy), .char_code(char_code),
      .enable(enable)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_addr[6:0];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic vbl_rise();
      vblnk = 1'b1;
      tick();
   endtask

   task automatic vbl_fall();
      vblnk = 1'b0;
      ticks(3);
   endtask

   initial begin
      ticks(2);
      chk("rst_msg_ready", msg_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_enable", enable, 0);
      chk("rst_char_code", char_code, 7'h20);
      rst = 1'b0;
      tick();
      chk("idle_msg_ready", msg_ready, 1);

      for (int f = 0; f < 2; f++) begin
         vbl_rise();
         vbl_fall();
      end
      chk("idle_enable", enable, 0);
      for (int i = 0; i <= 40; i++) begin
         char_xy = 8'(i);
         tick();
         chk("idle_lookup", char_code, 7'h20);
      end

      // Load message 2
      show = 1'b1;
      msg_id = 3'd2;
      msg_req = 1'b1;
      tick();
      msg_req = 1'b0;
      chk("m2_busy", busy, 1);
      chk("m2_ready_low", msg_ready, 0);
      chk("m2_addr0", rom_addr, 64);
      for (int i = 1; i < 32; i++) begin
         tick();
         chk("m2_addr", rom_addr, 64 + i);
      end
      ticks(4);
      chk("m2_wait_busy", busy, 1);
      chk("m2_wait_done", done, 0);
      chk("m2_wait_enable", enable, 0);
      char_xy = 8'd5;
      vbl_rise();
      chk("m2_done", done, 1);
      chk("m2_busy_fall", busy, 0);
      chk("m2_ready_in_done", msg_ready, 0);
      chk("m2_enable", enable, 1);
      tick();
      chk("m2_done_pulse", done, 0);
      chk("m2_ready_back", msg_ready, 1);
      chk("m2_char5", char_code, 7'h45);
      char_xy = 8'd32;
      tick();
      chk("m2_char32", char_code, 7'h20);
      char_xy = 8'd31;
      tick();
      chk("m2_char31", char_code, 7'h5f);
      vbl_fall();

      // Message 1 with msg_req held; msg_id switches to 3 after acceptance
      msg_id = 3'd1;
      msg_req = 1'b1;
      tick();
      chk("m1_addr0", rom_addr, 32);
      msg_id = 3'd3;
      ticks(40);
      chk("m1_wait_busy", busy, 1);
      chk("m1_wait_ready", msg_ready, 0);
      char_xy = 8'd5;
      vbl_rise();
      chk("m1_done", done, 1);
      chk("m1_ready_in_done", msg_ready, 0);
      tick();
      chk("m1_char5", char_code, 7'h25);
      chk("m3_ready", msg_ready, 1);
      tick();
      msg_req = 1'b0;
      chk("m3_busy", busy, 1);
      chk("m3_addr0", rom_addr, 96);
      vblnk = 1'b0;
      ticks(4);
      // vblank start in the middle of the fill is not used
      vbl_rise();
      chk("mid_fill_done", done, 0);
      chk("mid_fill_busy", busy, 1);
      chk("mid_fill_char5", char_code, 7'h25);
      vbl_fall();
      ticks(40);
      chk("m3_wait_busy", busy, 1);
      chk("m3_old_front", char_code, 7'h25);
      vbl_rise();
      chk("m3_done", done, 1);
      tick();
      chk("m3_char5", char_code, 7'h65);
      vbl_fall();

      // Blinking with BLINK_FRAMES=2
      blink_en = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         vbl_rise();
         chk("blink_enable", enable, blink_exp[k]);
         vbl_fall();
      end
      blink_en = 1'b0;
      tick();
      vbl_rise();
      chk("blink_off_enable", enable, 1);
      vbl_fall();
      show = 1'b0;
      vbl_rise();
      chk("show_off_enable", enable, 0);
      vbl_fall();
      show = 1'b1;
      vbl_rise();
      chk("show_on_enable", enable, 1);
      vbl_fall();

      // Reset in the middle of a fill
      msg_id = 3'd4;
      msg_req = 1'b1;
      tick();
      msg_req = 1'b0;
      ticks(10);
      chk("rstfill_addr", rom_addr, 138);
      rst = 1'b1;
      tick();
      chk("rstfill_ready", msg_ready, 0);
      chk("rstfill_busy", busy, 0);
      chk("rstfill_done", done, 0);
      chk("rstfill_addr0", rom_addr, 0);
      chk("rstfill_enable", enable, 0);
      chk("rstfill_char", char_code, 7'h20);
      rst = 1'b0;
      char_xy = 8'd5;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("rstfill_no_done", done, 0);
      end
      chk("rstfill_front_clear", char_code, 7'h20);
      chk("rstfill_ready_back", msg_ready, 1);
      msg_id = 3'd2;
      msg_req = 1'b1;
      tick();
      msg_req = 1'b0;
      chk("after_rst_busy", busy, 1);
      chk("after_rst_addr0", rom_addr, 64);
      ticks(40);
      vbl_rise();
      chk("after_rst_done", done, 1);
      chk("after_rst_enable", enable, 1);
      tick();
      chk("after_rst_char5", char_code, 7'h45);
      vbl_fall();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/text_msg_ctrl.md
Name: text_msg_ctrl

Overview:
- Controller and sequencer for the 32-character text overlay renderer.
- Loads a selected message from an external message ROM into a double-buffered 32-entry character buffer and swaps buffers only at vertical-blank start, so no frame shows a torn string.
- Serves the renderer's char_xy lookups with a character code and drives the renderer's enable, including frame-counted blinking.
- Sits between game control (requester), the message ROM, and the text renderer and its font ROM.

Parameters:
- WIDTH, 32, characters per message and buffer depth; power of two, maximum 32.
- MSG_ID_W, 3, message-select width; ROM holds 2^MSG_ID_W messages.
- BLINK_FRAMES, 30, frames per blink half-period; minimum 1.
- BLANK_CODE, 7'h20, code returned for out-of-range char_xy and held in buffers after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- msg_req  in  1  requester asks to load message msg_id.
- msg_id  in  MSG_ID_W  message select; sampled on acceptance.
- msg_ready  out  1  high only in IDLE; a request is accepted when msg_req&msg_ready.
- busy  out  1  high from acceptance until swap completes.
- done  out  1  one-cycle pulse in the cycle the new buffer becomes visible.
- rom_addr  out  MSG_ID_W+5  {msg_id_latched, idx[4:0]}.
- rom_data  in  7  ROM character code; valid one cycle after rom_addr.
- vblnk  in  1  vertical blank from the VGA timing chain.
- show  in  1  overlay visible request.
- blink_en  in  1  enables blinking.
- char_xy  in  8  character index requested by the renderer.
- char_code  out  7  code of front-buffer entry char_xy.
- enable  out  1  renderer enable.

Behaviour:
- Reset: msg_ready=0 in the reset cycle and 1 afterwards. busy=0, done=0, rom_addr=0, char_code=BLANK_CODE, enable=0.
- Reset also clears both buffers to BLANK_CODE, front_valid=0, frame counter=0, blink phase=1 (visible), and puts the FSM in IDLE. Reset mid-fill abandons the load; done is not produced.
- vblnk rising edge (vbl_start): vblnk high with its registered copy low. It is the only event that swaps buffers or updates enable.
- IDLE: msg_ready=1. On msg_req=1, latch msg_id, set idx=0, go to FILL. busy rises the next cycle. msg_req while not in IDLE is ignored, with no queuing.
- FILL: rom_addr={id,idx}, and idx increments each cycle for WIDTH cycles. rom_data is written into back[idx-1] one cycle later. The final write happens in the cycle after idx=WIDTH-1 is issued, then go to WAIT_VBL. Fill time is WIDTH+1 cycles.
- WAIT_VBL: hold until vbl_start, then swap front/back pointer, set front_valid=1, pulse done for 1 cycle, go to IDLE.
  - If vbl_start occurs during FILL, it is not used. The FSM waits for the next one.
  - busy falls in the same cycle as done, and msg_ready returns in the cycle after done.
- Lookup: 1-cycle latency. char_code <= (char_xy < WIDTH) ? front[char_xy[4:0]] : BLANK_CODE. Index by the low bits only after the range check; no wrap.
- Frame counter: increments on each vbl_start. At BLINK_FRAMES-1 it wraps to 0 and toggles the phase when blink_en=1. When blink_en=0, the counter is held at 0 and phase=1.
- enable is registered at vbl_start only: enable <= show & front_valid & phase. It is constant for a whole frame.
- If the toggle and a swap land on the same vbl_start, both take effect and enable uses the new front_valid.

Test Plan:
- Reset, then idle 2 frames -> msg_ready=1, enable=0, char_code=7'h20 for char_xy=0..40.
- Request msg_id=2 with ROM data=addr[6:0], show=1 -> rom_addr 64..95 over 32 cycles. done pulses at the first vbl_start after fill, and that same vbl_start sets enable=1. char_xy=5 then returns 7'h45 the next cycle, and char_xy=32 returns 7'h20.
- Request during FILL of msg 1 with msg_req held and msg_id=3 -> second request accepted only after done. The message 1 content is displayed for at least one frame before message 3 appears.
- vbl_start mid-FILL -> no swap, old front still returned, done at the following vbl_start.
- blink_en=1, BLINK_FRAMES=2, show=1, buffer loaded -> enable pattern over successive vbl_starts is 1,0,0,1,1,0. Drop blink_en -> enable=1 at the next vbl_start.
- Assert rst at FILL idx=10 -> outputs return to reset values, front cleared to 7'h20, no done pulse, and a new request is accepted normally afterwards.
